// File: rtl/cache_pkg.sv
// Shared types and PLRU tree helpers for the n-way cache controller.
// Tree node i sits at bit (WAYS-2-i) of the PLRU vector (root is the MSB).
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_REFILL
  } cache_state_e;

  function automatic int plru_pos(
    input int ways,
    input int node
  );
    return ways - 2 - node;
  endfunction

  function automatic int plru_child(
    input int   node,
    input logic dir
  );
    return 2 * node + 1 + (dir ? 1 : 0);
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree-PLRU victim selection and access update for one cache set.
// A node bit of 0 points at the lower-index half of its subtree.
module plru_tree
  import cache_pkg::*;
#(
  parameter  int WAYS = 4,
  localparam int WIDX = $clog2(WAYS)
) (
  input  logic [WAYS-2:0] plru_bits,
  input  logic [WIDX-1:0] access_way,
  output logic [WIDX-1:0] victim_way,
  output logic [WAYS-2:0] plru_next
);

  always_comb begin
    int node;
    node = 0;
    for (int l = 0; l < WIDX; l++) begin
      node = plru_child(node, plru_bits[plru_pos(WAYS, node)]);
    end
    victim_way = WIDX'(node - (WAYS - 1));
  end

  // Every node on the accessed way's path is turned to point away from it.
  always_comb begin
    int   node;
    logic dir;
    node      = 0;
    dir       = 1'b0;
    plru_next = plru_bits;
    for (int l = 0; l < WIDX; l++) begin
      dir = access_way[WIDX-1-l];
      plru_next[plru_pos(WAYS, node)] = ~dir;
      node = plru_child(node, dir);
    end
  end

endmodule

// File: rtl/cache_control_nway.sv
// Control FSM for a WAYS-way write-back, write-allocate cache.
// Drives the array write enables and the physical-memory handshake.
module cache_control_nway
  import cache_pkg::*;
#(
  parameter  int WAYS = 4,
  localparam int WIDX = $clog2(WAYS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [WAYS-1:0] hit,
  input  logic [WAYS-1:0] valid,
  input  logic [WAYS-1:0] dirty,
  input  logic [WAYS-2:0] plru_bits,
  input  logic            pmem_resp,
  output logic            mem_resp,
  output logic            pmem_read,
  output logic            pmem_write,
  output logic            pmem_addr_sel,
  output logic [WIDX-1:0] way_sel,
  output logic [WAYS-1:0] data_load,
  output logic [WAYS-1:0] tag_load,
  output logic [WAYS-1:0] valid_load,
  output logic [WAYS-1:0] dirty_load,
  output logic            data_src,
  output logic            dirty_in,
  output logic            plru_load,
  output logic [WAYS-2:0] plru_next
);

  cache_state_e    state_q, state_d;
  logic [WIDX-1:0] victim_q, victim_d;
  logic [WIDX-1:0] hit_way, inv_way, plru_way, miss_way;
  logic [WAYS-1:0] hv, hit_oh, vic_oh;
  logic [WAYS-2:0] tree_next;
  logic            is_write;

  assign hv       = hit & valid;
  assign is_write = mem_write & ~mem_read;

  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hv[i])     hit_way = WIDX'(i);
      if (!valid[i]) inv_way = WIDX'(i);
    end
  end

  plru_tree #(.WAYS(WAYS)) u_plru (
    .plru_bits  (plru_bits),
    .access_way (hit_way),
    .victim_way (plru_way),
    .plru_next  (tree_next)
  );

  assign miss_way = (&valid) ? plru_way : inv_way;
  assign hit_oh   = WAYS'(1) << hit_way;
  assign vic_oh   = WAYS'(1) << victim_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    way_sel       = '0;
    data_load     = '0;
    tag_load      = '0;
    valid_load    = '0;
    dirty_load    = '0;
    data_src      = 1'b0;
    dirty_in      = 1'b0;
    plru_load     = 1'b0;
    plru_next     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (|hv) begin
          mem_resp  = 1'b1;
          plru_load = 1'b1;
          plru_next = tree_next;
          way_sel   = hit_way;
          if (is_write) begin
            data_load  = hit_oh;
            dirty_load = hit_oh;
            dirty_in   = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          victim_d = miss_way;
          if (valid[miss_way] && dirty[miss_way])
            state_d = S_WRITEBACK;
          else
            state_d = S_REFILL;
        end
      end
      S_WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim_q;
        if (pmem_resp) state_d = S_REFILL;
      end
      S_REFILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          data_load  = vic_oh;
          tag_load   = vic_oh;
          valid_load = vic_oh;
          dirty_load = vic_oh;
          data_src   = 1'b1;
          state_d    = S_LOOKUP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
